// File: rtl/instr_cache_pkg.sv
// Shared definitions for the I-Cache state-tag controller: line state
// encodings, address field positions and the controller FSM states.
package instr_cache_pkg;

  localparam int OFFSET_WIDTH = 6;
  localparam int SET_LSB      = OFFSET_WIDTH;

  localparam logic [1:0] ST_I = 2'b10;
  localparam logic [1:0] ST_C = 2'b01;
  localparam logic [1:0] ST_D = 2'b00;

  typedef enum logic [3:0] {
    INIT,
    IDLE,
    LOOKUP,
    REFILL_REQ,
    REFILL_WAIT,
    FILL,
    INV_CMP,
    INV_WR,
    RESP
  } ctrl_state_e;

endpackage

// File: rtl/instr_tag_cmp.sv
// Combinational compare of a state-tag RAM word against a latched tag.
// hit needs a Clean line; valid_match accepts any non-Invalid line.
module instr_tag_cmp
  import instr_cache_pkg::*;
#(
  parameter int STATE_WIDTH = 2,
  parameter int TAG_WIDTH   = 22
) (
  input  logic [STATE_WIDTH+TAG_WIDTH-1:0] st_r_state_tag,
  input  logic [TAG_WIDTH-1:0]             tag,
  output logic                             hit,
  output logic                             valid_match
);

  logic [STATE_WIDTH-1:0] line_state;
  logic                   tag_eq;

  assign line_state  = st_r_state_tag[STATE_WIDTH+TAG_WIDTH-1:TAG_WIDTH];
  assign tag_eq      = (st_r_state_tag[TAG_WIDTH-1:0] == tag);
  // Dirty lines never occur in an I-Cache, so only Clean counts as a hit.
  assign hit         = tag_eq && (line_state == ST_C);
  assign valid_match = tag_eq && (line_state != ST_I);

endmodule

// File: rtl/instr_tag_lookup_ctrl.sv
// Initiator-side controller for the I-Cache state-tag RAM: post-reset sweep,
// fetch lookup with refill on miss, and coherence invalidation.
module instr_tag_lookup_ctrl
  import instr_cache_pkg::*;
#(
  parameter int SET_WIDTH   = 4,
  parameter int STATE_WIDTH = 2,
  parameter int TAG_WIDTH   = 22,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  output logic                             resp_valid,
  output logic                             resp_hit,
  output logic                             refill_valid,
  input  logic                             refill_ready,
  output logic [ADDR_WIDTH-1:0]            refill_addr,
  input  logic                             refill_done,
  input  logic                             inval_valid,
  output logic                             inval_ready,
  input  logic [ADDR_WIDTH-1:0]            inval_addr,
  output logic                             st_w_en,
  output logic [STATE_WIDTH+TAG_WIDTH-1:0] st_w_state_tag,
  output logic [SET_WIDTH-1:0]             st_rw_addr,
  input  logic [STATE_WIDTH+TAG_WIDTH-1:0] st_r_state_tag,
  output logic                             init_done
);

  localparam int TAG_LSB = SET_LSB + SET_WIDTH;

  ctrl_state_e            state_q, state_d;
  logic [SET_WIDTH-1:0]   sweep_cnt_q, sweep_cnt_d;
  logic [SET_WIDTH-1:0]   set_q, set_d;
  logic [TAG_WIDTH-1:0]   tag_q, tag_d;
  logic                   st_w_en_q, st_w_en_d;
  logic                   resp_valid_q, resp_valid_d;
  logic                   resp_hit_q, resp_hit_d;
  logic                   refill_valid_q, refill_valid_d;
  logic                   init_done_q, init_done_d;
  logic                   tag_hit, tag_valid_match;
  logic                   unused_offset_bits;

  assign unused_offset_bits = ^{req_addr[SET_LSB-1:0], inval_addr[SET_LSB-1:0]};

  instr_tag_cmp #(
    .STATE_WIDTH (STATE_WIDTH),
    .TAG_WIDTH   (TAG_WIDTH)
  ) u_tag_cmp (
    .st_r_state_tag (st_r_state_tag),
    .tag            (tag_q),
    .hit            (tag_hit),
    .valid_match    (tag_valid_match)
  );

  always_comb begin
    state_d        = state_q;
    sweep_cnt_d    = sweep_cnt_q;
    set_d          = set_q;
    tag_d          = tag_q;
    init_done_d    = init_done_q;
    req_ready      = 1'b0;
    inval_ready    = 1'b0;
    st_rw_addr     = set_q;
    st_w_state_tag = {ST_I, {TAG_WIDTH{1'b0}}};

    case (state_q)
      INIT: begin
        st_rw_addr = sweep_cnt_q;
        // The counter only moves once a write has actually been issued.
        if (st_w_en_q) begin
          sweep_cnt_d = sweep_cnt_q + 1'b1;
          if (sweep_cnt_q == '1) begin
            state_d     = IDLE;
            init_done_d = 1'b1;
          end
        end
      end
      IDLE: begin
        inval_ready = 1'b1;
        req_ready   = !inval_valid;
        if (inval_valid) begin
          st_rw_addr = inval_addr[TAG_LSB-1:SET_LSB];
          set_d      = inval_addr[TAG_LSB-1:SET_LSB];
          tag_d      = inval_addr[ADDR_WIDTH-1:TAG_LSB];
          state_d    = INV_CMP;
        end else begin
          st_rw_addr = req_addr[TAG_LSB-1:SET_LSB];
          if (req_valid) begin
            set_d   = req_addr[TAG_LSB-1:SET_LSB];
            tag_d   = req_addr[ADDR_WIDTH-1:TAG_LSB];
            state_d = LOOKUP;
          end
        end
      end
      LOOKUP:      state_d = tag_hit ? RESP : REFILL_REQ;
      REFILL_REQ:  if (refill_ready) state_d = REFILL_WAIT;
      REFILL_WAIT: if (refill_done) state_d = FILL;
      FILL: begin
        st_w_state_tag = {ST_C, tag_q};
        state_d        = RESP;
      end
      INV_CMP:     state_d = tag_valid_match ? INV_WR : IDLE;
      INV_WR: begin
        st_w_state_tag = {ST_I, tag_q};
        state_d        = IDLE;
      end
      RESP:        state_d = IDLE;
      default:     state_d = INIT;
    endcase

    // Registered strobes are derived from the state being entered.
    st_w_en_d      = state_d inside {INIT, FILL, INV_WR};
    resp_valid_d   = (state_d == RESP);
    resp_hit_d     = (state_d == RESP) && (state_q == LOOKUP);
    refill_valid_d = (state_d == REFILL_REQ);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= INIT;
      sweep_cnt_q    <= '0;
      set_q          <= '0;
      tag_q          <= '0;
      st_w_en_q      <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_hit_q     <= 1'b0;
      refill_valid_q <= 1'b0;
      init_done_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      sweep_cnt_q    <= sweep_cnt_d;
      set_q          <= set_d;
      tag_q          <= tag_d;
      st_w_en_q      <= st_w_en_d;
      resp_valid_q   <= resp_valid_d;
      resp_hit_q     <= resp_hit_d;
      refill_valid_q <= refill_valid_d;
      init_done_q    <= init_done_d;
    end
  end

  assign st_w_en      = st_w_en_q;
  assign resp_valid   = resp_valid_q;
  assign resp_hit     = resp_hit_q;
  assign refill_valid = refill_valid_q;
  assign init_done    = init_done_q;
  assign refill_addr  = {tag_q, set_q, {OFFSET_WIDTH{1'b0}}};

endmodule

// File: tb/tb_instr_tag_lookup_ctrl.sv
// Directed self-checking bench for instr_tag_lookup_ctrl with a behavioural
// 16-entry state-tag RAM that has a one-cycle registered read.
module tb_instr_tag_lookup_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        resp_valid;
  logic        resp_hit;
  logic        refill_valid;
  logic        refill_ready = 1'b0;
  logic [31:0] refill_addr;
  logic        refill_done = 1'b0;
  logic        inval_valid = 1'b0;
  logic        inval_ready;
  logic [31:0] inval_addr = '0;
  logic        st_w_en;
  logic [23:0] st_w_state_tag;
  logic [3:0]  st_rw_addr;
  logic [23:0] st_r_state_tag;
  logic        init_done;

  int tests_run    = 0;
  int tests_failed = 0;

  // Pre-load every set as Clean with tag 4 so a skipped sweep shows up as a false hit.
  logic [23:0] mem [16] = '{default: 24'h400004};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (st_w_en) mem[st_rw_addr] <= st_w_state_tag;
    st_r_state_tag <= mem[st_rw_addr];
  end

  instr_tag_lookup_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .resp_valid     (resp_valid),
    .resp_hit       (resp_hit),
    .refill_valid   (refill_valid),
    .refill_ready   (refill_ready),
    .refill_addr    (refill_addr),
    .refill_done    (refill_done),
    .inval_valid    (inval_valid),
    .inval_ready    (inval_ready),
    .inval_addr     (inval_addr),
    .st_w_en        (st_w_en),
    .st_w_state_tag (st_w_state_tag),
    .st_rw_addr     (st_rw_addr),
    .st_r_state_tag (st_r_state_tag),
    .init_done      (init_done)
  );

  task automatic checkOutput(input string name, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, observed, expected, $time);
    end
  endtask

  // Called at the negedge where reset is released; refill_done is cleared after the first cycle.
  task automatic checkSweep();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      refill_done = 1'b0;
      checkOutput("sweep_wen", st_w_en, 1);
      checkOutput("sweep_addr", st_rw_addr, i);
      checkOutput("sweep_data", st_w_state_tag, 32'h800000);
      checkOutput("sweep_req_ready", req_ready, 0);
      checkOutput("sweep_inval_ready", inval_ready, 0);
    end
    @(negedge clk);
    checkOutput("sweep_end_wen", st_w_en, 0);
    checkOutput("init_done", init_done, 1);
    checkOutput("idle_req_ready", req_ready, 1);
  endtask

  // Presents a lookup in IDLE and returns at the negedge of the LOOKUP cycle.
  task automatic applyStimulus(input logic [31:0] addr, input logic [3:0] exp_set);
    req_valid = 1'b1;
    req_addr  = addr;
    #1;
    checkOutput("req_ready", req_ready, 1);
    checkOutput("lookup_rw_addr", st_rw_addr, exp_set);
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("lookup_resp_valid", resp_valid, 0);
    checkOutput("lookup_wen", st_w_en, 0);
  endtask

  task automatic runMiss(input logic [31:0] addr, input logic [31:0] line,
                         input logic [3:0] exp_set, input logic [21:0] tag);
    applyStimulus(addr, exp_set);
    @(negedge clk);
    checkOutput("refill_valid", refill_valid, 1);
    checkOutput("refill_addr", refill_addr, line);
    @(negedge clk);
    checkOutput("refill_valid_held", refill_valid, 1);
    checkOutput("refill_addr_held", refill_addr, line);
    refill_ready = 1'b1;
    @(negedge clk);
    refill_ready = 1'b0;
    checkOutput("refill_valid_drop", refill_valid, 0);
    checkOutput("wait_wen", st_w_en, 0);
    @(negedge clk);
    checkOutput("wait_resp_valid", resp_valid, 0);
    refill_done = 1'b1;
    @(negedge clk);
    refill_done = 1'b0;
    checkOutput("fill_wen", st_w_en, 1);
    checkOutput("fill_addr", st_rw_addr, exp_set);
    checkOutput("fill_data", st_w_state_tag, {8'h00, 2'b01, tag});
    @(negedge clk);
    checkOutput("miss_resp_valid", resp_valid, 1);
    checkOutput("miss_resp_hit", resp_hit, 0);
    checkOutput("miss_resp_wen", st_w_en, 0);
    @(negedge clk);
    checkOutput("miss_resp_end", resp_valid, 0);
    checkOutput("miss_idle_ready", req_ready, 1);
  endtask

  task automatic runHit(input logic [31:0] addr, input logic [3:0] exp_set);
    applyStimulus(addr, exp_set);
    checkOutput("hit_no_refill_n1", refill_valid, 0);
    @(negedge clk);
    checkOutput("hit_resp_valid", resp_valid, 1);
    checkOutput("hit_resp_hit", resp_hit, 1);
    checkOutput("hit_no_refill", refill_valid, 0);
    checkOutput("hit_no_wen", st_w_en, 0);
    @(negedge clk);
    checkOutput("hit_resp_end", resp_valid, 0);
    checkOutput("hit_idle_ready", req_ready, 1);
  endtask

  // A competing fetch request is held alongside the invalidate to exercise priority.
  task automatic runInval(input logic [31:0] addr, input logic [3:0] exp_set,
                          input logic [21:0] tag, input logic expect_write);
    inval_valid = 1'b1;
    inval_addr  = addr;
    req_valid   = 1'b1;
    req_addr    = 32'h0000_1240;
    #1;
    checkOutput("inval_ready", inval_ready, 1);
    checkOutput("inval_blocks_req", req_ready, 0);
    checkOutput("inval_rw_addr", st_rw_addr, exp_set);
    @(negedge clk);
    inval_valid = 1'b0;
    req_valid   = 1'b0;
    checkOutput("inv_cmp_wen", st_w_en, 0);
    checkOutput("inv_cmp_resp", resp_valid, 0);
    @(negedge clk);
    checkOutput("inv_wr_wen", st_w_en, expect_write);
    if (expect_write) begin
      checkOutput("inv_wr_data", st_w_state_tag, {8'h00, 2'b10, tag});
      checkOutput("inv_wr_addr", st_rw_addr, exp_set);
      @(negedge clk);
      checkOutput("inv_done_wen", st_w_en, 0);
    end
    checkOutput("inv_idle_ready", inval_ready, 1);
  endtask

  initial begin
    @(negedge clk);
    checkOutput("rst_wen", st_w_en, 0);
    checkOutput("rst_data", st_w_state_tag, 32'h800000);
    checkOutput("rst_addr", st_rw_addr, 0);
    checkOutput("rst_init_done", init_done, 0);
    checkOutput("rst_req_ready", req_ready, 0);
    checkOutput("rst_resp_valid", resp_valid, 0);
    checkOutput("rst_refill_valid", refill_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    checkSweep();

    runMiss(32'h0000_1240, 32'h0000_1240, 4'd9, 22'h4);
    runHit(32'h0000_127C, 4'd9);
    runMiss(32'h0000_1640, 32'h0000_1640, 4'd9, 22'h5);
    runHit(32'h0000_1640, 4'd9);

    runInval(32'h0000_1640, 4'd9, 22'h5, 1'b1);
    runMiss(32'h0000_1640, 32'h0000_1640, 4'd9, 22'h5);
    runInval(32'h0000_1240, 4'd9, 22'h4, 1'b0);
    runHit(32'h0000_1640, 4'd9);

    applyStimulus(32'h0000_3000, 4'd0);
    @(negedge clk);
    checkOutput("r6_refill_valid", refill_valid, 1);
    refill_ready = 1'b1;
    @(negedge clk);
    refill_ready = 1'b0;
    checkOutput("r6_init_done_pre", init_done, 1);
    rst = 1'b1;
    #1;
    checkOutput("r6_refill_valid", refill_valid, 0);
    checkOutput("r6_refill_addr", refill_addr, 0);
    checkOutput("r6_wen", st_w_en, 0);
    checkOutput("r6_init_done", init_done, 0);
    checkOutput("r6_req_ready", req_ready, 0);
    checkOutput("r6_inval_ready", inval_ready, 0);
    checkOutput("r6_rw_addr", st_rw_addr, 0);
    checkOutput("r6_data", st_w_state_tag, 32'h800000);
    @(negedge clk);
    @(negedge clk);
    rst         = 1'b0;
    refill_done = 1'b1;
    checkSweep();

    refill_done = 1'b1;
    @(negedge clk);
    refill_done = 1'b0;
    checkOutput("late_done_wen", st_w_en, 0);
    checkOutput("late_done_resp", resp_valid, 0);
    checkOutput("late_done_ready", req_ready, 1);
    runMiss(32'h0000_127C, 32'h0000_1240, 4'd9, 22'h4);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
